// File: rtl/rom_arbiter.sv
// rom_arbiter
// Two-port arbiter in front of a single combinational ROM. Each requester
// presents an address with a valid/ready handshake. The winner's address is
// registered, the ROM is read for one cycle, and the word plus error flag are
// registered and returned. The response holds until the granted requester
// accepts it. A new transaction can start at most every three cycles.
//
// Parameters
//   addr_width : ROM address width in bits
//   data_width : ROM data width in bits
//
// Ports
//   clk_i        : sole clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_valid_i  : per-requester request valid (bit 0 = port 0)
//   req_addr0_i  : requested address, port 0
//   req_addr1_i  : requested address, port 1
//   req_ready_o  : one-hot grant in IDLE, zero otherwise
//   rsp_valid_o  : response valid, only for the granted requester
//   rsp_data_o   : registered ROM word for the current response
//   rsp_error_o  : registered ROM error for the current response
//   rsp_ready_i  : per-requester response accept
//   rom_addr_o   : address to the ROM (registered request address)
//   rom_data_i   : ROM word
//   rom_error_i  : ROM error flag
//
// Configuration
//   ROM_ARB_FIXED_PRIO_EN : when defined, port 0 always wins a tie and no
//                           last-grant pointer is kept; otherwise round-robin.

module rom_arbiter #(
   parameter int addr_width = 5,
   parameter int data_width = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            req_valid_i,
   input  logic [addr_width-1:0] req_addr0_i,
   input  logic [addr_width-1:0] req_addr1_i,
   output logic [1:0]            req_ready_o,
   output logic [1:0]            rsp_valid_o,
   output logic [data_width-1:0] rsp_data_o,
   output logic                  rsp_error_o,
   input  logic [1:0]            rsp_ready_i,
   output logic [addr_width-1:0] rom_addr_o,
   input  logic [data_width-1:0] rom_data_i,
   input  logic                  rom_error_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [addr_width-1:0] addr_q;
   logic                  grant_q;
   logic                  grant_idx;
   logic                  accept;

`ifdef ROM_ARB_FIXED_PRIO_EN
   // Port 0 always wins; port 1 is granted only when it requests alone.
   always_comb begin
      grant_idx = req_valid_i[0] ? 1'b0 : 1'b1;
   end
`else
   logic last_grant_q;

   // On a tie the port not granted last wins; a lone request always wins.
   always_comb begin
      if (&req_valid_i) begin
         grant_idx = ~last_grant_q;
      end else begin
         grant_idx = req_valid_i[0] ? 1'b0 : 1'b1;
      end
   end

   // Pointer resets to 1 so port 0 wins the first tie, and moves only when a
   // request is actually accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_grant_q <= 1'b1;
      end else if (accept) begin
         last_grant_q <= grant_idx;
      end
   end
`endif

   // Next-state and handshake outputs. Grants are suppressed while reset is
   // high so nothing is accepted in a reset cycle.
   always_comb begin
      state_d     = state_q;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rst_i && (|req_valid_i)) begin
               req_ready_o = grant_idx ? 2'b10 : 2'b01;
               accept      = 1'b1;
               state_d     = READ;
            end
         end
         READ: begin
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = grant_q ? 2'b10 : 2'b01;
            if (rsp_ready_i[grant_q]) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured request and captured ROM response. The ROM word is
   // sampled on the edge that ends READ, so the response is stable for the
   // whole RESP phase regardless of what the ROM does afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         grant_q     <= 1'b0;
         rsp_data_o  <= '0;
         rsp_error_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= grant_idx ? req_addr1_i : req_addr0_i;
            grant_q <= grant_idx;
         end
         if (state_q == READ) begin
            rsp_data_o  <= rom_data_i;
            rsp_error_o <= rom_error_i;
         end
      end
   end

   // The ROM always sees the last registered address, in READ and outside it.
   assign rom_addr_o = addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
// Directed, table-driven bench for rom_arbiter. A behavioural ROM returns
// 16'hBEEF at address 3 and 16'hA500 | addr elsewhere; its error flag is
// driven from the vector table. Each table row is one clock cycle: inputs are
// applied just after the rising edge and outputs are checked on the falling
// edge. A hand-written sequence covers reset in the middle of a response.

module tb_rom_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
   localparam bit fixed_prio = 1'b1;
`else
   localparam bit fixed_prio = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_valid_i;
   logic [4:0]  req_addr0_i;
   logic [4:0]  req_addr1_i;
   logic [1:0]  req_ready_o;
   logic [1:0]  rsp_valid_o;
   logic [15:0] rsp_data_o;
   logic        rsp_error_o;
   logic [1:0]  rsp_ready_i;
   logic [4:0]  rom_addr_o;
   logic [15:0] rom_data_i;
   logic        rom_error_i;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [1:0]  valid;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [1:0]  rrdy;
      logic        err;
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_rv;
      logic [15:0] exp_data;
      logic        exp_err;
      logic        chk_addr;
      logic [4:0]  exp_addr;
   } vec_t;

   vec_t vecs[$];

   rom_arbiter #(
      .addr_width(5),
      .data_width(16)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_valid_i(req_valid_i),
      .req_addr0_i(req_addr0_i),
      .req_addr1_i(req_addr1_i),
      .req_ready_o(req_ready_o),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o (rsp_data_o),
      .rsp_error_o(rsp_error_o),
      .rsp_ready_i(rsp_ready_i),
      .rom_addr_o (rom_addr_o),
      .rom_data_i (rom_data_i),
      .rom_error_i(rom_error_i)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural combinational ROM contents.
   always_comb begin
      rom_data_i = (rom_addr_o == 5'd3) ? 16'hBEEF : (16'hA500 | {11'd0, rom_addr_o});
   end

   function automatic vec_t mk(input logic [1:0] valid, input logic [4:0] a0,
                               input logic [4:0] a1, input logic [1:0] rrdy,
                               input logic err, input logic [1:0] exp_rdy,
                               input logic [1:0] exp_rv, input logic [15:0] exp_data,
                               input logic exp_err, input logic chk_addr,
                               input logic [4:0] exp_addr);
      vec_t v;
      v.valid    = valid;
      v.a0       = a0;
      v.a1       = a1;
      v.rrdy     = rrdy;
      v.err      = err;
      v.exp_rdy  = exp_rdy;
      v.exp_rv   = exp_rv;
      v.exp_data = exp_data;
      v.exp_err  = exp_err;
      v.chk_addr = chk_addr;
      v.exp_addr = exp_addr;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      req_valid_i = v.valid;
      req_addr0_i = v.a0;
      req_addr1_i = v.a1;
      rsp_ready_i = v.rrdy;
      rom_error_i = v.err;
   endtask

   task automatic check_vector(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      check_output({tag, ".req_ready"}, {30'd0, req_ready_o}, {30'd0, v.exp_rdy});
      check_output({tag, ".rsp_valid"}, {30'd0, rsp_valid_o}, {30'd0, v.exp_rv});
      check_output({tag, ".rsp_data"}, {16'd0, rsp_data_o}, {16'd0, v.exp_data});
      check_output({tag, ".rsp_error"}, {31'd0, rsp_error_o}, {31'd0, v.exp_err});
      if (v.chk_addr) begin
         check_output({tag, ".rom_addr"}, {27'd0, rom_addr_o}, {27'd0, v.exp_addr});
      end
   endtask

   initial begin
      logic [15:0] prev;
      logic [1:0]  oh;
      logic        g;

      // Back-to-back ties on addresses 1/2: alternate 0,1,0,1 in round-robin,
      // port 0 every time with fixed priority.
      prev = 16'h0000;
      for (int t = 0; t < 4; t++) begin
         g  = fixed_prio ? 1'b0 : t[0];
         oh = g ? 2'b10 : 2'b01;
         vecs.push_back(mk(2'b11, 5'd1, 5'd2, 2'b11, 1'b0, oh, 2'b00, prev, 1'b0, 1'b0, 5'd0));
         vecs.push_back(mk(2'b11, 5'd1, 5'd2, 2'b11, 1'b0, 2'b00, 2'b00, prev, 1'b0, 1'b1,
                           g ? 5'd2 : 5'd1));
         prev = g ? 16'hA502 : 16'hA501;
         vecs.push_back(mk(2'b11, 5'd1, 5'd2, 2'b11, 1'b0, 2'b00, oh, prev, 1'b0, 1'b0, 5'd0));
      end

      // Port 0 alone reads address 3 and completes immediately.
      vecs.push_back(mk(2'b01, 5'd3, 5'd0, 2'b01, 1'b0, 2'b01, 2'b00, prev, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd3, 5'd0, 2'b01, 1'b0, 2'b00, 2'b00, prev, 1'b0, 1'b1, 5'd3));
      vecs.push_back(mk(2'b00, 5'd3, 5'd0, 2'b01, 1'b0, 2'b00, 2'b01, 16'hBEEF, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd3, 5'd0, 2'b00, 1'b0, 2'b00, 2'b00, 16'hBEEF, 1'b0, 1'b1, 5'd3));

      // Port 0 at address 4 is held off for five cycles while only port 1's
      // response ready is high; port 1 requests meanwhile and then drops.
      vecs.push_back(mk(2'b01, 5'd4, 5'd7, 2'b10, 1'b0, 2'b01, 2'b00, 16'hBEEF, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b10, 5'd4, 5'd7, 2'b10, 1'b0, 2'b00, 2'b00, 16'hBEEF, 1'b0, 1'b1, 5'd4));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(2'b10, 5'd4, 5'd7, 2'b10, 1'b0, 2'b00, 2'b01, 16'hA504, 1'b0, 1'b0, 5'd0));
      end
      vecs.push_back(mk(2'b00, 5'd4, 5'd7, 2'b01, 1'b0, 2'b00, 2'b01, 16'hA504, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd4, 5'd7, 2'b00, 1'b0, 2'b00, 2'b00, 16'hA504, 1'b0, 1'b1, 5'd4));

      // Port 1 at address 6 with a ROM error, then a clean repeat.
      vecs.push_back(mk(2'b10, 5'd0, 5'd6, 2'b00, 1'b0, 2'b10, 2'b00, 16'hA504, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd0, 5'd6, 2'b00, 1'b1, 2'b00, 2'b00, 16'hA504, 1'b0, 1'b1, 5'd6));
      vecs.push_back(mk(2'b00, 5'd0, 5'd6, 2'b10, 1'b0, 2'b00, 2'b10, 16'hA506, 1'b1, 1'b0, 5'd0));
      vecs.push_back(mk(2'b10, 5'd0, 5'd6, 2'b00, 1'b0, 2'b10, 2'b00, 16'hA506, 1'b1, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd0, 5'd6, 2'b00, 1'b0, 2'b00, 2'b00, 16'hA506, 1'b1, 1'b1, 5'd6));
      vecs.push_back(mk(2'b00, 5'd0, 5'd6, 2'b10, 1'b0, 2'b00, 2'b10, 16'hA506, 1'b0, 1'b0, 5'd0));
      vecs.push_back(mk(2'b00, 5'd0, 5'd6, 2'b00, 1'b0, 2'b00, 2'b00, 16'hA506, 1'b0, 1'b0, 5'd0));

      // Reset with both requesters asserting: no grant, cleared outputs.
      rst_i       = 1'b1;
      req_valid_i = 2'b11;
      req_addr0_i = 5'd9;
      req_addr1_i = 5'd10;
      rsp_ready_i = 2'b11;
      rom_error_i = 1'b0;
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_output("reset.req_ready", {30'd0, req_ready_o}, 32'd0);
      check_output("reset.rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
      check_output("reset.rsp_data", {16'd0, rsp_data_o}, 32'd0);
      check_output("reset.rsp_error", {31'd0, rsp_error_o}, 32'd0);
      check_output("reset.rom_addr", {27'd0, rom_addr_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         @(negedge clk_i);
         check_vector(vecs[i], i);
         @(posedge clk_i);
         #1;
      end

      // Port 0 takes a transaction so a later tie would go to port 1 unless
      // reset restores the pointer.
      req_valid_i = 2'b01;
      req_addr0_i = 5'd3;
      rsp_ready_i = 2'b00;
      rom_error_i = 1'b0;
      @(negedge clk_i);
      check_output("rst_seq.accept", {30'd0, req_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      req_valid_i = 2'b00;
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_output("rst_seq.resp_valid", {30'd0, rsp_valid_o}, 32'd1);
      check_output("rst_seq.resp_data", {16'd0, rsp_data_o}, 32'h0000BEEF);

      // Reset pulsed in RESP aborts the response.
      rst_i       = 1'b1;
      req_valid_i = 2'b11;
      @(negedge clk_i);
      check_output("rst_seq.ready_in_reset", {30'd0, req_ready_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      req_valid_i = 2'b00;
      rsp_ready_i = 2'b11;
      @(negedge clk_i);
      check_output("rst_seq.post_valid", {30'd0, rsp_valid_o}, 32'd0);
      check_output("rst_seq.post_data", {16'd0, rsp_data_o}, 32'd0);
      check_output("rst_seq.post_error", {31'd0, rsp_error_o}, 32'd0);
      check_output("rst_seq.post_addr", {27'd0, rom_addr_o}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         #1;
         @(negedge clk_i);
         check_output($sformatf("rst_seq.no_resp%0d", i), {30'd0, rsp_valid_o}, 32'd0);
      end
      @(posedge clk_i);
      #1;

      // First tie after reset goes to port 0 in both builds.
      req_valid_i = 2'b11;
      req_addr0_i = 5'd1;
      req_addr1_i = 5'd2;
      rsp_ready_i = 2'b01;
      @(negedge clk_i);
      check_output("rst_seq.first_tie", {30'd0, req_ready_o}, 32'd1);
      @(posedge clk_i);
      #1;
      req_valid_i = 2'b00;
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_output("rst_seq.tie_valid", {30'd0, rsp_valid_o}, 32'd1);
      check_output("rst_seq.tie_data", {16'd0, rsp_data_o}, 32'h0000A501);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_output("rst_seq.tie_done", {30'd0, rsp_valid_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
- REQ-001 SHALL have parameter addr_width, default 5, ROM address width in bits.
- REQ-002 SHALL have parameter data_width, default 16, ROM data width in bits.
- REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
- REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
- REQ-005 SHALL have ports req_valid_i[1:0], input, 2, per-requester request valid (index 0 = port 0, index 1 = port 1).
- REQ-006 SHALL have ports req_addr0_i / req_addr1_i, input, addr_width each, requested ROM address.
- REQ-007 SHALL have port req_ready_o[1:0], output, 2, request accepted when valid and ready are both high on the same edge.
- REQ-008 SHALL have ports rsp_valid_o[1:0], output, 2, response valid per requester.
- REQ-009 SHALL have port rsp_data_o, output, data_width, shared registered response data.
- REQ-010 SHALL have port rsp_error_o, output, 1, registered ROM error for the current response.
- REQ-011 SHALL have port rsp_ready_i[1:0], input, 2, per-requester response accept.
- REQ-012 SHALL have ports rom_addr_o (output, addr_width), rom_data_i (input, data_width) and rom_error_i (input, 1), connecting to the combinational ROM.

Function
- REQ-013 SHALL implement a three-state FSM: IDLE, READ, RESP.
- REQ-014 In IDLE, req_ready_o SHALL be one-hot on the granted requester among asserted req_valid_i, or zero if none is valid; it SHALL be zero in READ and RESP.
- REQ-015 On acceptance the arbiter SHALL register the address and grant index, and move IDLE->READ.
- REQ-016 In READ, rom_addr_o SHALL drive the registered address; at the end of READ, rom_data_i and rom_error_i SHALL be captured into rsp_data_o/rsp_error_o, READ->RESP.
- REQ-017 In RESP, rsp_valid_o SHALL assert only for the granted index and hold with stable data/error until rsp_ready_i of that index is high on an edge, then RESP->IDLE.
- REQ-018 Latency: request accepted on edge N -> rsp_valid_o high from edge N+2; maximum throughput one transaction per 3 cycles.
- REQ-019 Arbitration SHALL be round-robin: if both valid, grant the index not granted last; a single valid request is always granted.
- REQ-020 The last-grant pointer SHALL update only on acceptance.
- REQ-021 rsp_ready_i of the non-granted index SHALL be ignored; rsp_ready_i asserted in IDLE/READ SHALL have no effect.
- REQ-022 A requester dropping req_valid_i without acceptance SHALL not change state.
- REQ-023 rom_addr_o SHALL hold the last registered address outside READ.
- REQ-024 rsp_error_o high SHALL still complete the handshake normally; rsp_data_o then carries whatever rom_data_i presented.

Reset
- REQ-025 While rst_i is high at an edge: state=IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_error_o=0, registered address=0, last-grant=1 (port 0 wins first tie).
- REQ-026 req_ready_o SHALL be 0 during any cycle where rst_i is high.
- REQ-027 Reset asserted in READ or RESP SHALL abort the transaction; no response SHALL be issued for it.

Configuration
- REQ-028 Macro ROM_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority, port 0 always beats port 1, and the last-grant pointer SHALL be omitted; when undefined, round-robin per REQ-019/020.

Verification
- REQ-029 Port 0 only, addr 0x03, ROM word 0x3 = 0xBEEF, rsp_ready_0 high -> rsp_valid_o=2'b01 at N+2, rsp_data_o=0xBEEF, rsp_error_o=0, IDLE at N+3.
- REQ-030 Both valid continuously, addrs 0x01/0x02, back-to-back -> grants alternate 0,1,0,1 (round-robin build); fixed-prio build -> port 0 every time.
- REQ-031 Response backpressure: rsp_ready_0 low 5 cycles -> rsp_valid_o and rsp_data_o stable 5 cycles, req_ready_o=0 throughout, completes on first ready.
- REQ-032 rom_error_i=1 during READ -> rsp_error_o=1 with rsp_valid_o, handshake completes, next transaction rsp_error_o=0.
- REQ-033 rst_i pulsed in RESP -> next edge rsp_valid_o=0, rsp_data_o=0, state IDLE; first tie after reset granted to port 0.
- REQ-034 rsp_ready_1 high while port 0 response pending -> no completion; rsp_valid_o stays 2'b01.
